// File: rtl/modport_dp.sv
// Datapath slice: general-purpose register file with two combinational read
// ports and one synchronous write port, plus a purely combinational ALU.
module modport_dp #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned GPR_AW       = 5,
  parameter int unsigned ALU_OPC_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [GPR_AW-1:0]       gpr_raddr1,
  output logic [XLEN-1:0]         gpr_rdata1,
  input  logic [GPR_AW-1:0]       gpr_raddr2,
  output logic [XLEN-1:0]         gpr_rdata2,
  input  logic [GPR_AW-1:0]       gpr_waddr,
  input  logic [XLEN-1:0]         gpr_wdata,
  input  logic                    gpr_wen,
  input  logic [ALU_OPC_SIZE-1:0] alu_opcode,
  input  logic [XLEN-1:0]         alu_src1,
  input  logic [XLEN-1:0]         alu_src2,
  output logic [XLEN-1:0]         alu_dst
);

  localparam int unsigned NUM_GPR = 2 ** GPR_AW;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [ALU_OPC_SIZE-1:0] OPC_ADD    = ALU_OPC_SIZE'(0);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_SUB    = ALU_OPC_SIZE'(1);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_LESS_S = ALU_OPC_SIZE'(2);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_LESS_U = ALU_OPC_SIZE'(3);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_XOR    = ALU_OPC_SIZE'(4);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_OR     = ALU_OPC_SIZE'(5);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_AND    = ALU_OPC_SIZE'(6);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_SL     = ALU_OPC_SIZE'(7);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_SRL    = ALU_OPC_SIZE'(8);
  localparam logic [ALU_OPC_SIZE-1:0] OPC_SRA    = ALU_OPC_SIZE'(9);

  logic [XLEN-1:0]    gpr_q [NUM_GPR];
  logic               gpr_we;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;

  // Register 0 is never written, so it keeps its reset value of zero.
  assign gpr_we = gpr_wen && (gpr_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_GPR); i++) begin
        gpr_q[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr_q[gpr_waddr] <= gpr_wdata;
    end
  end

  // Reads see the stored value only; a same-cycle write lands after the edge.
  assign gpr_rdata1 = (gpr_raddr1 == '0) ? '0 : gpr_q[gpr_raddr1];
  assign gpr_rdata2 = (gpr_raddr2 == '0) ? '0 : gpr_q[gpr_raddr2];

  assign shamt = alu_src2[SHAMT_W-1:0];
  assign lt_s  = $signed(alu_src1) < $signed(alu_src2);
  assign lt_u  = alu_src1 < alu_src2;

  // ALU result select; undefined opcodes produce zero.
  always_comb begin
    alu_dst = '0;
    case (alu_opcode)
      OPC_ADD:    alu_dst = alu_src1 + alu_src2;
      OPC_SUB:    alu_dst = alu_src1 - alu_src2;
      OPC_LESS_S: alu_dst = {{(XLEN-1){1'b0}}, lt_s};
      OPC_LESS_U: alu_dst = {{(XLEN-1){1'b0}}, lt_u};
      OPC_XOR:    alu_dst = alu_src1 ^ alu_src2;
      OPC_OR:     alu_dst = alu_src1 | alu_src2;
      OPC_AND:    alu_dst = alu_src1 & alu_src2;
      OPC_SL:     alu_dst = alu_src1 << shamt;
      OPC_SRL:    alu_dst = alu_src1 >> shamt;
      OPC_SRA:    alu_dst = XLEN'($signed(alu_src1) >>> shamt);
      default:    alu_dst = '0;
    endcase
  end

endmodule

// File: tb/tb_modport_dp.sv
// Scoreboard bench for modport_dp: stimulus pushes expected read/ALU results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_modport_dp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned OPCW = 4;
  localparam longint      MOD  = 64'sd4294967296;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   gpr_raddr1 = '0, gpr_raddr2 = '0, gpr_waddr = '0;
  logic [XLEN-1:0] gpr_wdata = '0, alu_src1 = '0, alu_src2 = '0;
  logic            gpr_wen = 1'b0;
  logic [OPCW-1:0] alu_opcode = '0;
  logic [XLEN-1:0] gpr_rdata1, gpr_rdata2, alu_dst;

  modport_dp #(.XLEN(XLEN), .GPR_AW(AW), .ALU_OPC_SIZE(OPCW)) dut (
    .clk(clk), .rst(rst),
    .gpr_raddr1(gpr_raddr1), .gpr_rdata1(gpr_rdata1),
    .gpr_raddr2(gpr_raddr2), .gpr_rdata2(gpr_rdata2),
    .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .gpr_wen(gpr_wen),
    .alu_opcode(alu_opcode), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_dst(alu_dst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] alu;
  } exp_t;

  exp_t            exp_q  [$];
  string           name_q [$];
  logic [XLEN-1:0] model  [32];
  int              total = 0;
  int              bad   = 0;

  // Reference ALU built from plain integer arithmetic on 64-bit values.
  function automatic logic [XLEN-1:0] ref_alu(int opc, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    longint ua, ub, sa, sb, p, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = (ua >= MOD / 2) ? ua - MOD : ua;
    sb = (ub >= MOD / 2) ? ub - MOD : ub;
    sh = int'(ub % 32);
    p  = longint'(1) << sh;
    case (opc)
      0: r = (ua + ub) % MOD;
      1: r = (ua - ub + MOD) % MOD;
      2: r = (sa < sb) ? 1 : 0;
      3: r = (ua < ub) ? 1 : 0;
      4: r = ua ^ ub;
      5: r = ua | ub;
      6: r = ua & ub;
      7: r = (ua * p) % MOD;
      8: r = ua / p;
      9: r = (sa >= 0) ? sa / p : ((-(((-sa) + p - 1) / p)) + MOD) % MOD;
      default: r = 0;
    endcase
    return r[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] ref_rd(int addr);
    return (addr == 0) ? '0 : model[addr];
  endfunction

  // One stimulus cycle: entered just after a rising edge, returns likewise.
  task automatic drive(input logic r, input int ra1, input int ra2, input int wa,
                       input logic [XLEN-1:0] wd, input logic we, input int opc,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string nm);
    exp_t e;
    rst        = r;
    gpr_raddr1 = AW'(ra1);
    gpr_raddr2 = AW'(ra2);
    gpr_waddr  = AW'(wa);
    gpr_wdata  = wd;
    gpr_wen    = we;
    alu_opcode = OPCW'(opc);
    alu_src1   = a;
    alu_src2   = b;
    if (r) for (int i = 0; i < 32; i++) model[i] = '0;
    e.rd1 = ref_rd(ra1);
    e.rd2 = ref_rd(ra2);
    e.alu = ref_alu(opc, a, b);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    if (!r && we && wa != 0) model[wa] = wd;
    #1;
  endtask

  task automatic rd(input int ra1, input int ra2, input string nm);
    drive(1'b0, ra1, ra2, 0, '0, 1'b0, 0, '0, '0, nm);
  endtask

  task automatic alu(input int opc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string nm);
    drive(1'b0, 0, 0, 0, '0, 1'b0, opc, a, b, nm);
  endtask

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, ".rd1"}, gpr_rdata1, e.rd1);
      check({nm, ".rd2"}, gpr_rdata2, e.rd2);
      check({nm, ".alu"}, alu_dst, e.alu);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset release: every register reads zero on both ports.
    for (int i = 0; i < 32; i++) rd(i, 31 - i, "reset_read");

    // Write x5, attempt x0, then read both on both ports.
    drive(1'b0, 0, 0, 5, 32'hDEADBEEF, 1'b1, 0, '0, '0, "wr_x5");
    drive(1'b0, 0, 0, 0, 32'h00001234, 1'b1, 0, '0, '0, "wr_x0");
    rd(5, 0, "rd_x5_x0");
    rd(0, 5, "rd_x0_x5");

    // Same-cycle read and write of x7: old value, then new after the edge.
    drive(1'b0, 7, 7, 7, 32'h55, 1'b1, 0, '0, '0, "rw_x7_same");
    rd(7, 7, "rd_x7_after");
    drive(1'b0, 7, 5, 5, 32'h0, 1'b0, 0, '0, '0, "wen_low");
    rd(5, 7, "rd_after_wen_low");

    // ALU boundary vectors.
    alu(0, 32'hFFFFFFFF, 32'h1, "add_wrap");
    alu(1, 32'h0, 32'h1, "sub_wrap");
    alu(2, 32'hFFFFFFFF, 32'h1, "less_s");
    alu(3, 32'hFFFFFFFF, 32'h1, "less_u");
    alu(7, 32'h80000010, 32'h24, "sl");
    alu(8, 32'h80000010, 32'h24, "srl");
    alu(9, 32'h80000010, 32'h24, "sra");
    alu(9, 32'h7FFFFFF0, 32'hFFFFFFE4, "sra_pos");
    alu(15, 32'hFFFFFFFF, 32'hFFFFFFFF, "opc15");
    alu(10, 32'h12345678, 32'h9ABCDEF0, "opc10");

    // Randomized mixed traffic.
    for (int n = 0; n < 300; n++) begin
      logic [XLEN-1:0] a, b;
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      drive(1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), a, b, "rand");
    end

    // Asynchronous reset mid-cycle with x3 nonzero; writes blocked while held.
    drive(1'b0, 0, 0, 3, 32'hA5A5A5A5, 1'b1, 0, '0, '0, "wr_x3");
    rd(3, 3, "rd_x3_set");
    drive(1'b1, 3, 3, 3, 32'h11111111, 1'b1, 0, 32'h5, 32'h7, "rst_async_x3");
    drive(1'b1, 3, 9, 9, 32'h22222222, 1'b1, 1, 32'h5, 32'h7, "rst_held_wr");
    drive(1'b0, 9, 3, 9, 32'hCAFEF00D, 1'b1, 4, 32'hF0F0, 32'h0FF0, "first_wr_after_rst");
    rd(9, 3, "rd_x9_after_rst");

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
